// File: rtl/act_pool_pkg.sv
// rtl/act_pool_pkg.sv - shared constants, types and states for the activation pooling stage
// Contents: DW/DIM/OUT_DIM constants, act_t element type, act_mat_t matrix type,
//           sum_t widened accumulator, pool_state_e FSM states.
package act_pool_pkg;
    localparam int DW      = 16;
    localparam int DIM     = 10;
    localparam int OUT_DIM = DIM / 2;
    localparam int IDXW    = 3;

    typedef logic signed [DW-1:0]   act_t;
    typedef logic signed [DW+1:0]   sum_t;
    typedef act_t [DIM-1:0][DIM-1:0] act_mat_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(OUT_DIM - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } pool_state_e;
endpackage

// File: rtl/pool_window4.sv
// rtl/pool_window4.sv - combinational reduction of a 2x2 window to one pooled value
// Ports: i_a..i_d window elements (signed), i_avg average select (only with
//        ACT_POOL_AVG_EN defined), o_result pooled value.
// Macro: ACT_POOL_AVG_EN adds floor-average pooling alongside max.
module pool_window4
    import act_pool_pkg::*;
(
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_b,
    input  logic signed [DW-1:0] i_c,
    input  logic signed [DW-1:0] i_d,
`ifdef ACT_POOL_AVG_EN
    input  logic                 i_avg,
`endif
    output logic signed [DW-1:0] o_result
);
    act_t w_max_ab;
    act_t w_max_cd;
    act_t w_max;

    // Operands are signed, so -32768 < -1 < 0 holds; ties simply pass the shared value.
    assign w_max_ab = (i_a > i_b) ? i_a : i_b;
    assign w_max_cd = (i_c > i_d) ? i_c : i_d;
    assign w_max    = (w_max_ab > w_max_cd) ? w_max_ab : w_max_cd;

`ifdef ACT_POOL_AVG_EN
    sum_t w_sum;
    act_t w_avg;

    // Two guard bits make the 4-way sum exact; >>> floors toward -inf,
    // and the quotient always fits back into DW bits.
    assign w_sum    = sum_t'(i_a) + sum_t'(i_b) + sum_t'(i_c) + sum_t'(i_d);
    assign w_avg    = act_t'(w_sum >>> 2);
    assign o_result = i_avg ? w_avg : w_max;
`else
    assign o_result = w_max;
`endif
endmodule

// File: rtl/act_maxpool_stream.sv
// rtl/act_maxpool_stream.sv - snapshot a DIMxDIM activation matrix and stream its 2x2 pooled result
// Ports: clk, rst (async, active-high); start begins a pass from IDLE; in_matrix[row][col];
//        out_ready consumer accept; busy pass in progress; out_valid/out_data/out_row/out_col
//        pooled word and its index; done one-cycle pulse after the last accept.
// Macro: ACT_POOL_AVG_EN adds pool_mode input (1 = average, 0 = max), sampled at start.
module act_maxpool_stream
    import act_pool_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DIM-1:0][DIM-1:0][DW-1:0] in_matrix,
`ifdef ACT_POOL_AVG_EN
    input  logic                          pool_mode,
`endif
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          out_valid,
    output logic signed [DW-1:0]          out_data,
    output logic [IDXW-1:0]               out_row,
    output logic [IDXW-1:0]               out_col,
    output logic                          done
);
    pool_state_e     r_state;
    pool_state_e     w_next_state;
    act_mat_t        r_snap;
    act_t            r_data;
    logic [IDXW-1:0] r_row;
    logic [IDXW-1:0] r_col;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;
    logic            w_accept;
    logic            w_last;
    logic [IDXW-1:0] w_sel_row;
    logic [IDXW-1:0] w_sel_col;
    logic [IDXW:0]   w_r0;
    logic [IDXW:0]   w_r1;
    logic [IDXW:0]   w_c0;
    logic [IDXW:0]   w_c1;
    act_t            w_win;
`ifdef ACT_POOL_AVG_EN
    logic            r_mode;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // w_sel_* names the window to load on this edge: (0,0) from LOAD,
    // the successor of the current index on an accept in STREAM.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_sel_row    = '0;
        w_sel_col    = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                w_next_state = STREAM;
            end
            STREAM: begin
                w_accept = r_valid & out_ready;
                w_last   = (r_row == LAST_IDX) && (r_col == LAST_IDX);
                if (r_col == LAST_IDX) begin
                    w_sel_row = r_row + 1'b1;
                    w_sel_col = '0;
                end else begin
                    w_sel_row = r_row;
                    w_sel_col = r_col + 1'b1;
                end
                if (w_accept && w_last) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_r0 = {w_sel_row, 1'b0};
    assign w_r1 = {w_sel_row, 1'b1};
    assign w_c0 = {w_sel_col, 1'b0};
    assign w_c1 = {w_sel_col, 1'b1};

    pool_window4 u_window (
        .i_a      (r_snap[w_r0][w_c0]),
        .i_b      (r_snap[w_r0][w_c1]),
        .i_c      (r_snap[w_r1][w_c0]),
        .i_d      (r_snap[w_r1][w_c1]),
`ifdef ACT_POOL_AVG_EN
        .i_avg    (r_mode),
`endif
        .o_result (w_win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap  <= '0;
            r_data  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef ACT_POOL_AVG_EN
            r_mode  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_snap <= in_matrix;
                        r_busy <= 1'b1;
`ifdef ACT_POOL_AVG_EN
                        r_mode <= pool_mode;
`endif
                    end
                end
                LOAD: begin
                    r_data  <= w_win;
                    r_row   <= '0;
                    r_col   <= '0;
                    r_valid <= 1'b1;
                end
                STREAM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_data <= w_win;
                            r_row  <= w_sel_row;
                            r_col  <= w_sel_col;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign done      = r_done;
endmodule

// File: tb/tb_act_maxpool_stream.sv
// tb/tb_act_maxpool_stream.sv - randomized self-checking bench for act_maxpool_stream
module tb_act_maxpool_stream;
    import act_pool_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 out_ready;
    act_mat_t             in_matrix;
    logic                 busy;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic [IDXW-1:0]      out_row;
    logic [IDXW-1:0]      out_col;
    logic                 done;
`ifdef ACT_POOL_AVG_EN
    logic                 pool_mode;
`endif

    always #5 clk = ~clk;

    act_maxpool_stream dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_matrix (in_matrix),
`ifdef ACT_POOL_AVG_EN
        .pool_mode (pool_mode),
`endif
        .out_ready (out_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .done      (done)
    );

    typedef struct {
        int data;
        int row;
        int col;
    } word_t;

    int    checks = 0;
    int    failures = 0;
    word_t exp_q[$];
    int    obs[OUT_DIM][OUT_DIM];
    int    accepts = 0;
    int    done_count = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int el(input act_mat_t m, input int i, input int j);
        return int'(m[i][j]);
    endfunction

    function automatic act_mat_t rand_mat();
        act_mat_t m;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                m[i][j] = act_t'($urandom_range(0, 65535));
        return m;
    endfunction

    // Reference: plain-integer max / floor-average over each 2x2 block, row-major.
    task automatic build_model(input act_mat_t m, input bit avg);
        exp_q.delete();
        for (int r = 0; r < OUT_DIM; r++) begin
            for (int c = 0; c < OUT_DIM; c++) begin
                int v[4];
                int res;
                int s;
                int rem;
                v[0] = el(m, 2*r, 2*c);
                v[1] = el(m, 2*r, 2*c+1);
                v[2] = el(m, 2*r+1, 2*c);
                v[3] = el(m, 2*r+1, 2*c+1);
                if (avg) begin
                    s   = v[0] + v[1] + v[2] + v[3];
                    rem = ((s % 4) + 4) % 4;
                    res = (s - rem) / 4;
                end else begin
                    res = v[0];
                    for (int k = 1; k < 4; k++)
                        if (v[k] > res) res = v[k];
                end
                exp_q.push_back('{data: res, row: r, col: c});
            end
        end
    endtask

    // Compare process: every cycle the outputs are meaningful.
    initial begin
        logic                 prev_valid = 1'b0;
        logic                 prev_ready = 1'b0;
        logic                 prev_done = 1'b0;
        logic signed [DW-1:0] prev_data = '0;
        logic [IDXW-1:0]      prev_row = '0;
        logic [IDXW-1:0]      prev_col = '0;
        word_t                w;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_ready = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (prev_valid && !prev_ready)
                    check(out_valid && out_data == prev_data && out_row == prev_row && out_col == prev_col,
                          "stall_hold", {out_valid, out_row, out_col, out_data}, {1'b1, prev_row, prev_col, prev_data});
                if (out_valid) begin
                    check(busy, "busy_while_valid", busy, 1);
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_word", out_data, 0);
                    end else begin
                        w = exp_q[0];
                        check(int'(out_data) == w.data, "word_data", out_data, w.data);
                        check(int'(out_row) == w.row && int'(out_col) == w.col, "word_index",
                              out_row * 10 + out_col, w.row * 10 + w.col);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            obs[out_row][out_col] = int'(out_data);
                            accepts++;
                        end
                    end
                end
                if (done) begin
                    done_count++;
                    check(exp_q.size() == 0 && !out_valid && !busy, "done_after_last", exp_q.size(), 0);
                    check(!prev_done, "done_single_cycle", prev_done, 0);
                end
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_done  = done;
                prev_data  = out_data;
                prev_row   = out_row;
                prev_col   = out_col;
            end
        end
    end

    task automatic start_pass(input act_mat_t m, input bit avg);
        in_matrix = m;
`ifdef ACT_POOL_AVG_EN
        pool_mode = avg;
`endif
        start = 1'b1;
        build_model(m, avg);
        accepts = 0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
    task automatic run_stream(input int ready_mode, input int disturb_at, input int abort_after,
                              output int first_valid, output int n_done);
        int n = 0;
        bit fin = 1'b0;
        int d0 = done_count;
        first_valid = -1;
        n_done = -1;
        while (!fin && n < 400) begin
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (n % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (n == disturb_at) begin
                start = 1'b1;
                in_matrix = rand_mat();
            end else begin
                start = 1'b0;
            end
            if (abort_after > 0 && accepts == abort_after) begin
                rst = 1'b1;
                #1;
                check({busy, out_valid, out_data, out_row, out_col, done} == '0, "abort_outputs_zero",
                      {busy, out_valid, out_data, out_row, out_col, done}, 0);
                exp_q.delete();
                @(posedge clk);
                #1 rst = 1'b0;
                fin = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                n++;
                if (out_valid && first_valid < 0) first_valid = n;
                if (done) begin
                    fin = 1'b1;
                    n_done = n;
                end
            end
        end
        start = 1'b0;
        check(fin, "pass_finished", n, 0);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (abort_after > 0) begin
            check(done_count == d0, "abort_no_done", done_count - d0, 0);
        end else begin
            check(done_count == d0 + 1, "done_once", done_count - d0, 1);
            check(accepts == OUT_DIM * OUT_DIM, "accept_total", accepts, OUT_DIM * OUT_DIM);
        end
    endtask

    initial begin
        act_mat_t m;
        act_mat_t saved;
        int fv;
        int nd;

        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        in_matrix = '0;
`ifdef ACT_POOL_AVG_EN
        pool_mode = 1'b0;
`endif
        #1;
        check({busy, out_valid, out_data, out_row, out_col, done} == '0, "reset_outputs",
              {busy, out_valid, out_data, out_row, out_col, done}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Ramp matrix, always ready: latency, throughput, known values.
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                m[i][j] = act_t'(i * 10 + j);
        start_pass(m, 1'b0);
        check(!out_valid && busy, "load_cycle", {out_valid, busy}, 2'b01);
        run_stream(0, -1, 0, fv, nd);
        check(fv == 1, "first_valid_latency", fv, 1);
        check(nd == 26, "done_latency", nd, 26);
        check(obs[0][0] == 11, "ramp_00", obs[0][0], 11);
        check(obs[2][3] == 57, "ramp_23", obs[2][3], 57);
        check(obs[4][4] == 99, "ramp_44", obs[4][4], 99);

        // Negative values: signed compare.
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                m[i][j] = act_t'(-5);
        m[3][3] = act_t'(-32768);
        m[8][9] = act_t'(-1);
        start_pass(m, 1'b0);
        run_stream(0, -1, 0, fv, nd);
        check(obs[1][1] == -5, "neg_11", obs[1][1], -5);
        check(obs[4][4] == -1, "neg_44", obs[4][4], -1);

        // Backpressure pattern 1,0,0 plus a start/matrix disturbance mid-stream.
        m = rand_mat();
        start_pass(m, 1'b0);
        run_stream(1, 5, 0, fv, nd);

        // Abort after 7 accepts, then a fresh full pass.
        m = rand_mat();
        start_pass(m, 1'b0);
        run_stream(2, -1, 7, fv, nd);
        saved = rand_mat();
        start_pass(saved, 1'b0);
        run_stream(2, -1, 0, fv, nd);

        // Random passes with random backpressure.
        for (int p = 0; p < 3; p++) begin
            m = rand_mat();
            start_pass(m, 1'b0);
            run_stream(2, 3 + p, 0, fv, nd);
        end

`ifdef ACT_POOL_AVG_EN
        m = rand_mat();
        m[0][0] = act_t'(-1);
        m[0][1] = act_t'(-2);
        m[1][0] = act_t'(-3);
        m[1][1] = act_t'(-4);
        m[0][2] = act_t'(1);
        m[0][3] = act_t'(2);
        m[1][2] = act_t'(3);
        m[1][3] = act_t'(5);
        start_pass(m, 1'b1);
        run_stream(2, -1, 0, fv, nd);
        check(obs[0][0] == -3, "avg_neg", obs[0][0], -3);
        check(obs[0][1] == 2, "avg_pos", obs[0][1], 2);
        m = rand_mat();
        start_pass(m, 1'b0);
        run_stream(0, -1, 0, fv, nd);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/act_maxpool_stream.md
Name: act_maxpool_stream

Overview:
Downstream neighbour of the leaky-ReLU activation stage. On a start pulse it snapshots the 10x10 signed 16-bit activation matrix, applies 2x2 stride-2 max pooling, and streams the 5x5 result, one word per cycle, in row-major order. Output uses a valid/ready handshake toward the result writer / next layer.

Parameters:
DIM, 10, input matrix side; must be even.
DW, 16, activation width, signed two's complement.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin a pooling pass; sampled only while idle
in_matrix  in  DW x DIM x DIM  signed activation matrix, indexed [row][col]
out_ready  in  1  consumer can accept out_data this cycle
busy  out  1  pass in progress
out_valid  out  1  out_data/out_row/out_col valid
out_data  out  DW  signed pooled value
out_row  out  3  pooled row index, 0..DIM/2-1
out_col  out  3  pooled col index, 0..DIM/2-1
done  out  1  single-cycle pulse after the last word is accepted

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. All outputs are 0, snapshot buffer is 0, state is IDLE.
- States: IDLE, LOAD, STREAM.
- IDLE:
  - busy=0.
  - If start=1 at an edge: snapshot <= in_matrix, busy <= 1, state <= LOAD.
- LOAD:
  - Next edge: out_data <= window(0,0), out_row=0, out_col=0, out_valid <= 1, state <= STREAM.
  - Latency: start edge + 2 edges to first valid word.
- window(r,c): signed max of snapshot[2r][2c], [2r][2c+1], [2r+1][2c], [2r+1][2c+1]. Compare is signed, so -32768 < -1 < 0. Ties return that value. No saturation is needed.
- STREAM:
  - If out_valid & out_ready at an edge, the word is accepted:
    - If index is (4,4): out_valid <= 0, busy <= 0, done <= 1 for one cycle, state <= IDLE.
    - Otherwise: advance the index (col++, wrapping to 0 with row++), and load the next window into out_data in the same edge.
  - Throughput: 1 word/cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_data/out_row/out_col hold stable.
- Once out_valid is asserted, it never drops before acceptance.
- start while busy is ignored, and the snapshot is not disturbed.
- start on the same edge that done is set is ignored. The earliest restart is the edge after done.
- in_matrix changes after the start edge have no effect on the current pass.
- rst asserted mid-pass aborts immediately to the reset state:
  - No done pulse.
  - The partial stream is discarded by the consumer.
- Total cycles per pass with out_ready=1: 1 (LOAD) + 25 (STREAM) to the last accept; done appears in the following cycle.

Optional Feature:
Macro ACT_POOL_AVG_EN.
- Defined:
  - Adds input pool_mode (1 bit), sampled together with the snapshot at the start edge.
  - pool_mode=1 selects average pooling: the 4-value sum is computed in DW+2 bits, then arithmetic shift right by 2 (floor toward -inf), giving a DW-bit result.
  - pool_mode=0 selects max pooling.
- Undefined: no pool_mode port; max pooling only.

Decomposition:
Shared package act_pool_pkg:
- DW, DIM, OUT_DIM=DIM/2 constants.
- act_t typedef (logic signed [DW-1:0]).
- pool_state_e enum {IDLE, LOAD, STREAM}.

Sub-module pool_window4: purely combinational reduction of four act_t values to one result. It computes max, plus average when ACT_POOL_AVG_EN is defined. One instance is fed by index-selected snapshot elements.

Test Plan:
1. in_matrix[i][j] = i*10+j, start, out_ready=1 -> first out_valid 2 cycles after start; 25 words in consecutive cycles with out_data = 20r+2c+11 (e.g. (0,0)=11, (4,4)=99); done pulses once.
2. All elements -5, except [3][3]=-32768 and [8][9]=-1 -> (1,1)=-5 and (4,4)=-1; signed compare verified.
3. out_ready toggling 1,0,0,1,... -> data/row/col stable while stalled; no word lost or duplicated; 25 total accepts.
4. start re-pulsed during STREAM and in_matrix changed -> ignored; output matches the original snapshot.
5. rst asserted after word 7 -> outputs 0 immediately; no done pulse; a new start then produces a full correct pass.
6. ACT_POOL_AVG_EN defined, pool_mode=1, window {-1,-2,-3,-4} -> sum -10 >>> 2 = -3; window {1,2,3,5} -> 2.
